// File: rtl/controle_pkg.sv
// Shared decode types and constants for the EX/MEM sequencer.
package controle_pkg;

  localparam int ULA_OP_W = 8;
  localparam int CLASSE_W = 4;

  localparam logic [CLASSE_W-1:0] CLS_ALU_RR = 4'd0;
  localparam logic [CLASSE_W-1:0] CLS_ALU_RI = 4'd1;
  localparam logic [CLASSE_W-1:0] CLS_LOAD   = 4'd2;
  localparam logic [CLASSE_W-1:0] CLS_STORE  = 4'd3;
  localparam logic [CLASSE_W-1:0] CLS_NOP    = 4'd4;

  localparam logic [ULA_OP_W-1:0] ULA_PASS_A = 8'h00;

  typedef enum logic [1:0] {IDLE, EXEC, WB, LOADER} estado_t;

  typedef struct packed {
    logic [ULA_OP_W-1:0] ula_op;
    logic                mux;
    logic                md_we;
    logic                rb_we;
    logic                rb_sel;
    logic                ilegal;
  } decod_t;

  // NOP and every illegal class go straight to writeback without an EXEC cycle.
  function automatic logic pula_exec(input logic [CLASSE_W-1:0] cls);
    return cls >= CLS_NOP;
  endfunction

endpackage

// File: rtl/decodificador_instr.sv
// Combinational decode of a 16-bit instruction word into datapath controls.
module decodificador_instr
  import controle_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int CLS_W   = CLASSE_W
) (
  input  logic [INSTR_W-1:0] instr_i,
  output decod_t             decod_o
);

  logic [CLS_W-1:0] cls;
  logic             unused_bits;

  assign cls         = instr_i[INSTR_W-1 -: CLS_W];
  assign unused_bits = ^instr_i[3:0];

  always_comb begin
    decod_o = '0;
    case (cls)
      CLS_ALU_RR: begin
        decod_o.ula_op = instr_i[11:4];
        decod_o.rb_we  = 1'b1;
      end
      CLS_ALU_RI: begin
        decod_o.ula_op = instr_i[11:4];
        decod_o.mux    = 1'b1;
        decod_o.rb_we  = 1'b1;
      end
      CLS_LOAD: begin
        decod_o.ula_op = ULA_PASS_A;
        decod_o.rb_we  = 1'b1;
        decod_o.rb_sel = 1'b1;
      end
      CLS_STORE: begin
        decod_o.ula_op = ULA_PASS_A;
        decod_o.md_we  = 1'b1;
      end
      CLS_NOP: decod_o = '0;
      default: decod_o.ilegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_ex_men.sv
// EX/MEM sequencer: IDLE -> EXEC -> WB per instruction, one outstanding at a time.
// Optional data-memory loader arbitration when CONTROLE_LOADER_EN is defined.
module controle_ex_men
  import controle_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OP_W    = ULA_OP_W,
  parameter int CLS_W   = CLASSE_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instrucao,
  output logic [OP_W-1:0]    ula_op,
  output logic               controle_mux_ula,
  output logic               md_hab_escrita,
  output logic               rb_hab_escrita,
  output logic               rb_sel_mem,
  output logic               done,
`ifdef CONTROLE_LOADER_EN
  input  logic               ld_req,
  input  logic               ld_we,
  output logic               ld_gnt,
  output logic               md_sel_loader,
`endif
  output logic               erro,
  output logic               busy
);

  estado_t            estado_q, estado_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               erro_q, erro_d;
  logic               ld_pede;
  decod_t             dec;

  decodificador_instr #(.INSTR_W(INSTR_W), .CLS_W(CLS_W)) u_decod (
    .instr_i (instr_q),
    .decod_o (dec)
  );

`ifdef CONTROLE_LOADER_EN
  assign ld_pede       = ld_req;
  assign ld_gnt        = (estado_q == LOADER);
  assign md_sel_loader = (estado_q == LOADER);
`else
  assign ld_pede = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    instr_d  = instr_q;
    erro_d   = erro_q;
    case (estado_q)
      IDLE: begin
        // The loader has priority over a simultaneous instruction offer.
        if (ld_pede) begin
          estado_d = LOADER;
        end else if (instr_valid) begin
          instr_d  = instrucao;
          estado_d = pula_exec(instrucao[INSTR_W-1 -: CLS_W]) ? WB : EXEC;
        end
      end
      EXEC: estado_d = WB;
      WB: begin
        if (dec.ilegal) erro_d = 1'b1;
        estado_d = IDLE;
      end
      LOADER: if (!ld_pede) estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= IDLE;
      instr_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      instr_q  <= instr_d;
      erro_q   <= erro_d;
    end
  end

  // Outputs decode the current state only, so reset drops them without a clock.
  always_comb begin
    instr_ready      = 1'b0;
    ula_op           = '0;
    controle_mux_ula = 1'b0;
    md_hab_escrita   = 1'b0;
    rb_hab_escrita   = 1'b0;
    rb_sel_mem       = 1'b0;
    done             = 1'b0;
    case (estado_q)
      IDLE: instr_ready = !ld_pede;
      EXEC: begin
        ula_op           = OP_W'(dec.ula_op);
        controle_mux_ula = dec.mux;
        md_hab_escrita   = dec.md_we;
      end
      WB: begin
        ula_op           = OP_W'(dec.ula_op);
        controle_mux_ula = dec.mux;
        rb_hab_escrita   = dec.rb_we;
        rb_sel_mem       = dec.rb_sel;
        done             = 1'b1;
      end
      LOADER: begin
`ifdef CONTROLE_LOADER_EN
        md_hab_escrita = ld_we;
`endif
      end
      default: instr_ready = 1'b0;
    endcase
  end

  assign erro = erro_q;
  assign busy = (estado_q != IDLE);

endmodule

// File: tb/tb_controle_ex_men.sv
// Bench for controle_ex_men: scoreboard of expected retire results per instruction.
module tb_controle_ex_men;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instrucao;
  logic [7:0]  ula_op;
  logic        controle_mux_ula;
  logic        md_hab_escrita;
  logic        rb_hab_escrita;
  logic        rb_sel_mem;
  logic        done;
  logic        erro;
  logic        busy;
`ifdef CONTROLE_LOADER_EN
  logic        ld_req;
  logic        ld_we;
  logic        ld_gnt;
  logic        md_sel_loader;
`endif

  controle_ex_men dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instrucao        (instrucao),
    .ula_op           (ula_op),
    .controle_mux_ula (controle_mux_ula),
    .md_hab_escrita   (md_hab_escrita),
    .rb_hab_escrita   (rb_hab_escrita),
    .rb_sel_mem       (rb_sel_mem),
    .done             (done),
`ifdef CONTROLE_LOADER_EN
    .ld_req           (ld_req),
    .ld_we            (ld_we),
    .ld_gnt           (ld_gnt),
    .md_sel_loader    (md_sel_loader),
`endif
    .erro             (erro),
    .busy             (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] ula;
    logic       mux;
    logic       md_we;
    logic       rb_we;
    logic       rb_sel;
    logic       ilegal;
    int         lat;
  } esp_t;

  esp_t fila[$];
  logic erro_m;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic esp_t modelo(input logic [15:0] w);
    esp_t e;
    logic [3:0] c;
    c = w[15:12];
    e.ula    = (c == 4'd0 || c == 4'd1) ? w[11:4] : 8'h00;
    e.mux    = (c == 4'd1);
    e.md_we  = (c == 4'd3);
    e.rb_we  = (c <= 4'd2);
    e.rb_sel = (c == 4'd2);
    e.ilegal = (c > 4'd4);
    e.lat    = (c >= 4'd4) ? 1 : 2;
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after retire.
  task automatic emite(input logic [15:0] w, input string nome);
    esp_t e;
    esp_t p;
    int   md_cnt;
    int   rb_cnt;
    bit   viu;
    e = modelo(w);
    chk({nome, "_ready_idle"}, instr_ready, 1);
    instr_valid = 1'b1;
    instrucao   = w;
    fila.push_back(e);
    @(posedge clock);
    md_cnt = 0;
    rb_cnt = 0;
    viu    = 0;
    for (int c = 1; c <= 5 && !viu; c++) begin
      @(negedge clock);
      if (md_hab_escrita) md_cnt++;
      if (rb_hab_escrita) rb_cnt++;
      chk({nome, "_busy"}, busy, 1);
      if (c == 1 && e.lat == 2) begin
        chk({nome, "_exec_ready"}, instr_ready, 0);
        chk({nome, "_exec_ula"}, ula_op, e.ula);
        chk({nome, "_exec_mux"}, controle_mux_ula, e.mux);
        chk({nome, "_exec_md_we"}, md_hab_escrita, e.md_we);
        chk({nome, "_exec_done"}, done, 0);
      end
      if (done) begin
        viu = 1;
        if (fila.size() == 0) begin
          chk({nome, "_fila_vazia"}, 1, 0);
        end else begin
          p = fila.pop_front();
          chk({nome, "_lat"}, c, p.lat);
          chk({nome, "_wb_ula"}, ula_op, p.ula);
          chk({nome, "_wb_mux"}, controle_mux_ula, p.mux);
          chk({nome, "_wb_rb_we"}, rb_hab_escrita, p.rb_we);
          chk({nome, "_wb_rb_sel"}, rb_sel_mem, p.rb_sel);
          if (p.ilegal) erro_m = 1'b1;
        end
      end
      // A different word offered while busy must be ignored.
      if (c == 1) begin
        instr_valid = 1'b1;
        instrucao   = 16'h1FF0;
      end else begin
        instr_valid = 1'b0;
      end
    end
    if (!viu) chk({nome, "_done_timeout"}, 0, 1);
    @(negedge clock);
    instr_valid = 1'b0;
    chk({nome, "_pos_ready"}, instr_ready, 1);
    chk({nome, "_pos_busy"}, busy, 0);
    chk({nome, "_pos_done"}, done, 0);
    chk({nome, "_pos_mux"}, controle_mux_ula, 0);
    chk({nome, "_pos_erro"}, erro, erro_m);
    chk({nome, "_md_we_cnt"}, md_cnt, e.md_we);
    chk({nome, "_rb_we_cnt"}, rb_cnt, e.rb_we);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instrucao   = 16'h0000;
    erro_m      = 1'b0;
`ifdef CONTROLE_LOADER_EN
    ld_req = 1'b0;
    ld_we  = 1'b0;
`endif
    #3;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_erro", erro, 0);
    chk("rst_md_we", md_hab_escrita, 0);
    chk("rst_rb_we", rb_hab_escrita, 0);
    chk("rst_ula", ula_op, 0);
    chk("rst_done", done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    emite(16'h0050, "alu_rr");
    emite(16'h10A0, "alu_ri");
    emite(16'h3ABC, "store");
    emite(16'h2123, "load");
    emite(16'h9000, "ilegal");
    emite(16'h4000, "nop");
    emite(16'h0330, "alu_rr2");

    // Asynchronous reset in the middle of a STORE's EXEC cycle.
    chk("rst_mid_ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instrucao   = 16'h3000;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    chk("rst_mid_md_we_before", md_hab_escrita, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_md_we", md_hab_escrita, 0);
    chk("rst_mid_ready", instr_ready, 1);
    chk("rst_mid_erro", erro, 0);
    chk("rst_mid_busy", busy, 0);
    erro_m = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    emite(16'h1070, "pos_reset");

`ifdef CONTROLE_LOADER_EN
    ld_req      = 1'b1;
    ld_we       = 1'b1;
    instr_valid = 1'b1;
    instrucao   = 16'h0050;
    #1;
    chk("ld_arb_ready", instr_ready, 0);
    @(negedge clock);
    chk("ld_gnt", ld_gnt, 1);
    chk("ld_sel", md_sel_loader, 1);
    chk("ld_ready", instr_ready, 0);
    chk("ld_md_we_1", md_hab_escrita, 1);
    chk("ld_rb_we", rb_hab_escrita, 0);
    ld_we = 1'b0;
    #1;
    chk("ld_md_we_0", md_hab_escrita, 0);
    @(negedge clock);
    chk("ld_gnt_held", ld_gnt, 1);
    ld_req = 1'b0;
    @(negedge clock);
    chk("ld_gnt_rel", ld_gnt, 0);
    chk("ld_sel_rel", md_sel_loader, 0);
    emite(16'h0050, "pos_loader");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
